// File: rtl/insn_decode_stage_pkg.sv
// Shared types and opcode constants for the fetch-to-issue decode stage.
package insn_decode_stage_pkg;

    typedef logic [4:0] RegId;
    typedef logic [9:0] SysRegId;

    typedef enum logic [2:0] {
        IC_OTHER,
        IC_NOP,
        IC_MTS,
        IC_MFS,
        IC_RET,
        IC_JSRR
    } InsnClass;

    typedef struct packed {
        InsnClass cls;
        RegId     rd;
        RegId     ra;
        logic     rd_we;
        SysRegId  sysreg;
    } DecodedInsn;

    localparam logic [7:0]  OPC_MTS = 8'h0D;
    localparam logic [7:0]  OPC_MFS = 8'h0C;
    localparam logic [4:0]  GRP_SEQ = 5'b01001;
    localparam int unsigned DEC_W   = $bits(DecodedInsn);

    function automatic logic is_branch(InsnClass c);
        return (c == IC_RET) || (c == IC_JSRR);
    endfunction

    function automatic logic is_sysreg(InsnClass c);
        return (c == IC_MTS) || (c == IC_MFS);
    endfunction

endpackage

// File: rtl/insn_decode_lane.sv
// Single-opcode classifier and field extractor; purely combinational.
module insn_decode_lane
    import insn_decode_stage_pkg::*;
(
    input  logic [31:0]      op,
    output logic [DEC_W-1:0] dec
);

    DecodedInsn d;
    logic       sys_grp;
    logic       seq_grp;

    always_comb begin
        sys_grp  = (op[31:23] == 9'd0);
        seq_grp  = (op[31:27] == GRP_SEQ);
        d        = '0;
        d.cls    = IC_OTHER;
        d.rd     = op[22:18];
        d.ra     = op[17:13];
        d.rd_we  = 1'b1;
        // Classes are tested in priority order; each clears the fields it does not use.
        if (sys_grp && (op[7:2] == 6'd0) && op[0]) begin
            d       = '0;
            d.cls   = IC_NOP;
        end else if (sys_grp && (op[7:0] == OPC_MTS)) begin
            d        = '0;
            d.cls    = IC_MTS;
            d.ra     = op[17:13];
            d.sysreg = {op[22:18], op[12:8]};
        end else if (sys_grp && (op[7:0] == OPC_MFS)) begin
            d        = '0;
            d.cls    = IC_MFS;
            d.rd     = op[22:18];
            d.rd_we  = 1'b1;
            d.sysreg = op[17:8];
        end else if (seq_grp && (op[26:23] == 4'b0000)) begin
            d       = '0;
            d.cls   = IC_RET;
        end else if (seq_grp && (op[26:23] == 4'b0010) && (op[20:18] == 3'b000)) begin
            d       = '0;
            d.cls   = IC_JSRR;
            d.ra    = op[17:13];
        end
    end

    assign dec = d;

endmodule

// File: rtl/insn_decode_stage.sv
// Registered decode stage: holds one fetch bundle and issues it downstream in chunks.
module insn_decode_stage
    import insn_decode_stage_pkg::*;
#(
    parameter int unsigned LANES         = 2,
    parameter int unsigned PC_W          = 32,
    parameter int unsigned SYSREG_SERIAL = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       in_lane_valid,
    input  logic [LANES*32-1:0]    in_insn,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES-1:0]       out_lane_valid,
    output logic [LANES*DEC_W-1:0] out_dec,
    output logic [PC_W-1:0]        out_pc
);

    localparam int unsigned PTR_W = $clog2(LANES + 1);

    logic                   hold_valid_q, hold_valid_d;
    logic [LANES-1:0]       hold_lv_q, hold_lv_d;
    logic [LANES*32-1:0]    hold_insn_q, hold_insn_d;
    logic [PC_W-1:0]        hold_pc_q, hold_pc_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;

    logic [LANES*DEC_W-1:0] dec_all;
    logic [LANES-1:0]       chunk_mask;
    logic [PTR_W-1:0]       end_ptr;
    logic                   last_chunk;
    logic                   taken, stop, has_br, rest, serial;
    InsnClass               scan_cls;
    logic                   accept, fire;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        insn_decode_lane u_lane (
            .op  (hold_insn_q[32*g +: 32]),
            .dec (dec_all[DEC_W*g +: DEC_W])
        );
    end

    // Chunk = remaining lanes from ptr, cut before a later serialising op, or inclusively at a branch.
    always_comb begin
        chunk_mask = '0;
        end_ptr    = ptr_q;
        taken      = 1'b0;
        stop       = 1'b0;
        has_br     = 1'b0;
        rest       = 1'b0;
        serial     = 1'b0;
        scan_cls   = IC_OTHER;
        for (int unsigned i = 0; i < LANES; i++) begin
            scan_cls = InsnClass'(dec_all[DEC_W*i + (DEC_W-3) +: 3]);
            serial   = (SYSREG_SERIAL != 0) && is_sysreg(scan_cls);
            if (hold_valid_q && hold_lv_q[i] && (i >= 32'(ptr_q)) && !stop) begin
                if (serial && taken) begin
                    stop = 1'b1;
                end else begin
                    chunk_mask[i] = 1'b1;
                    end_ptr       = PTR_W'(i + 1);
                    taken         = 1'b1;
                    if (serial || is_branch(scan_cls)) stop = 1'b1;
                    if (is_branch(scan_cls)) has_br = 1'b1;
                end
            end
        end
        for (int unsigned i = 0; i < LANES; i++) begin
            if (hold_lv_q[i] && (i >= 32'(end_ptr))) rest = 1'b1;
        end
        last_chunk = has_br || !rest;
    end

    always_comb begin
        out_dec = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (chunk_mask[i]) out_dec[DEC_W*i +: DEC_W] = dec_all[DEC_W*i +: DEC_W];
        end
    end

    assign out_valid      = |chunk_mask;
    assign out_lane_valid = chunk_mask;
    assign out_pc         = hold_pc_q;
    assign in_ready       = !flush && (!hold_valid_q || (out_ready && last_chunk));
    assign accept         = in_valid && in_ready;
    assign fire           = out_valid && out_ready;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_lv_d    = hold_lv_q;
        hold_insn_d  = hold_insn_q;
        hold_pc_d    = hold_pc_q;
        ptr_d        = ptr_q;
        if (flush) begin
            hold_valid_d = 1'b0;
            ptr_d        = '0;
        end else if (accept) begin
            hold_valid_d = |in_lane_valid;
            hold_lv_d    = in_lane_valid;
            hold_insn_d  = in_insn;
            hold_pc_d    = in_pc;
            ptr_d        = '0;
        end else if (fire) begin
            if (last_chunk) begin
                hold_valid_d = 1'b0;
                ptr_d        = '0;
            end else begin
                ptr_d = end_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_lv_q    <= '0;
            hold_insn_q  <= '0;
            hold_pc_q    <= '0;
            ptr_q        <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_lv_q    <= hold_lv_d;
            hold_insn_q  <= hold_insn_d;
            hold_pc_q    <= hold_pc_d;
            ptr_q        <= ptr_d;
        end
    end

endmodule

// File: tb/tb_insn_decode_stage.sv
// Directed bench for insn_decode_stage with a three-lane instance.
module tb_insn_decode_stage;
    import insn_decode_stage_pkg::*;

    localparam int unsigned LANES = 3;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned DW    = LANES * DEC_W;

    localparam logic [31:0] NOP    = 32'h0000_0001;
    localparam logic [31:0] MTS1   = 32'h0000_010D;
    localparam logic [31:0] MFS1   = 32'h0011_550C;
    localparam logic [31:0] RET    = 32'h4800_0000;
    localparam logic [31:0] JSRR6  = 32'h4900_C000;
    localparam logic [31:0] OTH1   = 32'h8014_E000;  // rd=5 ra=7
    localparam logic [31:0] OTH2   = 32'h800D_2000;  // rd=3 ra=9

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [LANES-1:0]    in_lane_valid = '0;
    logic [LANES*32-1:0] in_insn = '0;
    logic [PC_W-1:0]     in_pc = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [LANES-1:0]    out_lane_valid;
    logic [DW-1:0]       out_dec;
    logic [PC_W-1:0]     out_pc;

    int checks = 0;
    int failures = 0;

    logic [DEC_W-1:0] d_nop, d_mts, d_mfs, d_ret, d_jsrr, d_oth1, d_oth2, z;

    insn_decode_stage #(
        .LANES         (LANES),
        .PC_W          (PC_W),
        .SYSREG_SERIAL (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_lane_valid  (in_lane_valid),
        .in_insn        (in_insn),
        .in_pc          (in_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_lane_valid (out_lane_valid),
        .out_dec        (out_dec),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [DEC_W-1:0] mk(InsnClass c, logic [4:0] rd, logic [4:0] ra,
                                            logic we, logic [9:0] sr);
        DecodedInsn d;
        d.cls    = c;
        d.rd     = rd;
        d.ra     = ra;
        d.rd_we  = we;
        d.sysreg = sr;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [LANES-1:0] lv,
                           input logic [DW-1:0] dec, input logic [PC_W-1:0] pc);
        chk({tag, ".valid"}, 128'(out_valid), 128'(v));
        chk({tag, ".lane_valid"}, 128'(out_lane_valid), 128'(lv));
        chk({tag, ".dec"}, 128'(out_dec), 128'(dec));
        chk({tag, ".pc"}, 128'(out_pc), 128'(pc));
    endtask

    task automatic drive(input logic v, input logic [LANES-1:0] lv, input logic [31:0] l0,
                         input logic [31:0] l1, input logic [31:0] l2, input logic [PC_W-1:0] pc);
        in_valid      = v;
        in_lane_valid = lv;
        in_insn       = {l2, l1, l0};
        in_pc         = pc;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        z      = '0;
        d_nop  = mk(IC_NOP,  5'd0, 5'd0, 1'b0, 10'h000);
        d_mts  = mk(IC_MTS,  5'd0, 5'd0, 1'b0, 10'h001);
        d_mfs  = mk(IC_MFS,  5'd4, 5'd0, 1'b1, 10'h155);
        d_ret  = mk(IC_RET,  5'd0, 5'd0, 1'b0, 10'h000);
        d_jsrr = mk(IC_JSRR, 5'd0, 5'd6, 1'b0, 10'h000);
        d_oth1 = mk(IC_OTHER, 5'd5, 5'd7, 1'b1, 10'h000);
        d_oth2 = mk(IC_OTHER, 5'd3, 5'd9, 1'b1, 10'h000);

        // Reset state
        step(); #1;
        chk_out("reset", 1'b0, 3'b000, '0, '0);
        chk("reset.in_ready", 128'(in_ready), 128'(1'b1));

        // 1: plain two-lane bundles back to back
        step(); rst_n = 1'b1; out_ready = 1'b1;
        drive(1'b1, 3'b011, NOP, OTH1, 32'h0, 32'h1000); #1;
        chk("t1.in_ready0", 128'(in_ready), 128'(1'b1));
        step(); drive(1'b1, 3'b011, OTH2, NOP, 32'h0, 32'h2000); #1;
        chk_out("t1.a", 1'b1, 3'b011, {z, d_oth1, d_nop}, 32'h1000);
        chk("t1.in_ready1", 128'(in_ready), 128'(1'b1));
        step(); drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0); #1;
        chk_out("t1.b", 1'b1, 3'b011, {z, d_nop, d_oth2}, 32'h2000);
        step(); #1;
        chk("t1.empty", 128'(out_valid), 128'(1'b0));

        // 2: MTS in the middle splits the bundle into three chunks
        drive(1'b1, 3'b111, OTH1, MTS1, OTH2, 32'h3000); #1;
        step(); drive(1'b1, 3'b001, NOP, 32'h0, 32'h0, 32'h4000); #1;
        chk_out("t2.c0", 1'b1, 3'b001, {z, z, d_oth1}, 32'h3000);
        chk("t2.in_ready0", 128'(in_ready), 128'(1'b0));
        step(); #1;
        chk_out("t2.c1", 1'b1, 3'b010, {z, d_mts, z}, 32'h3000);
        chk("t2.in_ready1", 128'(in_ready), 128'(1'b0));
        step(); #1;
        chk_out("t2.c2", 1'b1, 3'b100, {d_oth2, z, z}, 32'h3000);
        chk("t2.in_ready2", 128'(in_ready), 128'(1'b1));
        step(); drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0); #1;
        chk_out("t2.next", 1'b1, 3'b001, {z, z, d_nop}, 32'h4000);
        step(); #1;
        chk("t2.empty", 128'(out_valid), 128'(1'b0));

        // 3: RET ends the bundle; JSRR likewise, inclusive
        drive(1'b1, 3'b011, RET, OTH1, 32'h0, 32'h5000);
        step(); drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0); #1;
        chk_out("t3.ret", 1'b1, 3'b001, {z, z, d_ret}, 32'h5000);
        chk("t3.in_ready", 128'(in_ready), 128'(1'b1));
        step(); #1;
        chk("t3.dropped", 128'(out_valid), 128'(1'b0));
        drive(1'b1, 3'b111, OTH1, JSRR6, OTH2, 32'h5800);
        step(); drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0); #1;
        chk_out("t3.jsrr", 1'b1, 3'b011, {z, d_jsrr, d_oth1}, 32'h5800);
        step(); #1;
        chk("t3.jsrr_dropped", 128'(out_valid), 128'(1'b0));

        // 4: backpressure holds outputs stable
        out_ready = 1'b0;
        drive(1'b1, 3'b011, NOP, OTH2, 32'h0, 32'h6000);
        step(); drive(1'b1, 3'b001, MFS1, 32'h0, 32'h0, 32'h7000);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk_out("t4.stall", 1'b1, 3'b011, {z, d_oth2, d_nop}, 32'h6000);
            chk("t4.in_ready", 128'(in_ready), 128'(1'b0));
            step();
        end
        out_ready = 1'b1; #1;
        chk("t4.release", 128'(in_ready), 128'(1'b1));
        step(); drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0); #1;
        chk_out("t4.mfs", 1'b1, 3'b001, {z, z, d_mfs}, 32'h7000);
        step(); #1;
        chk("t4.empty", 128'(out_valid), 128'(1'b0));

        // 5: flush after the first of three chunks
        drive(1'b1, 3'b111, OTH1, MTS1, OTH2, 32'h8000);
        step(); drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0); #1;
        chk_out("t5.c0", 1'b1, 3'b001, {z, z, d_oth1}, 32'h8000);
        step(); flush = 1'b1;
        drive(1'b1, 3'b011, NOP, OTH1, 32'h0, 32'h8800); #1;
        chk("t5.in_ready_flush", 128'(in_ready), 128'(1'b0));
        step(); flush = 1'b0;
        drive(1'b1, 3'b011, NOP, OTH1, 32'h0, 32'h9000); #1;
        chk_out("t5.flushed", 1'b0, 3'b000, '0, 32'h8000);
        chk("t5.in_ready", 128'(in_ready), 128'(1'b1));
        step(); drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0); #1;
        chk_out("t5.new", 1'b1, 3'b011, {z, d_oth1, d_nop}, 32'h9000);
        step(); #1;
        chk("t5.empty", 128'(out_valid), 128'(1'b0));

        // 6: asynchronous reset mid-bundle, then an empty bundle
        drive(1'b1, 3'b111, OTH1, MTS1, OTH2, 32'hA000);
        step(); drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0); #1;
        chk_out("t6.c0", 1'b1, 3'b001, {z, z, d_oth1}, 32'hA000);
        #2 rst_n = 1'b0; #1;
        chk_out("t6.async", 1'b0, 3'b000, '0, '0);
        step(); rst_n = 1'b1;
        step(); #1;
        chk_out("t6.after", 1'b0, 3'b000, '0, '0);
        drive(1'b1, 3'b000, OTH1, OTH2, NOP, 32'hB000); #1;
        chk("t6.empty_ready", 128'(in_ready), 128'(1'b1));
        step(); drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0); #1;
        chk("t6.empty_valid", 128'(out_valid), 128'(1'b0));
        chk("t6.empty_lanes", 128'(out_lane_valid), 128'(3'b000));
        step(); #1;
        chk("t6.empty_valid2", 128'(out_valid), 128'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
